// File: rtl/tx_serial_pkg.sv
// Shared definitions for the parametrised serial transmitter: parity-mode
// codes, FSM state encoding (also exported on db_estado) and a small helper.
package tx_serial_pkg;

  localparam logic [1:0] NENHUMA = 2'b00;
  localparam logic [1:0] PAR     = 2'b01;
  localparam logic [1:0] IMPAR   = 2'b10;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CARREGA   = 4'd1,
    TRANSMITE = 4'd2,
    FINAL     = 4'd3
  } estado_t;

  // Reserved mode 2'b11 falls through to "no parity".
  function automatic logic paridade_ativa(input logic [1:0] modo);
    return (modo == PAR) || (modo == IMPAR);
  endfunction

endpackage

// File: rtl/tx_serial_param_if.sv
// Host-side bundle of the serial transmitter.
//
// Handshake: partida is an edge-triggered enqueue request with no ready
// signal. The word on dados is captured on the first cycle partida is seen
// high; cheio is the only backpressure indication, and a request made while
// cheio is high is dropped and reported by a one-cycle descartado pulse.
// pronto pulses once at the end of every transmitted frame.
interface tx_serial_param_if #(
  parameter int N_DADOS = 7
);
  logic               partida;
  logic [N_DADOS-1:0] dados;
  logic [1:0]         modo_paridade;
  logic               dois_stop;
  logic               saida_serial;
  logic               pronto;
  logic               ocupado;
  logic               cheio;
  logic               descartado;
  logic [3:0]         db_estado;

  modport master (
    output partida, dados, modo_paridade, dois_stop,
    input  saida_serial, pronto, ocupado, cheio, descartado, db_estado
  );

  modport slave (
    input  partida, dados, modo_paridade, dois_stop,
    output saida_serial, pronto, ocupado, cheio, descartado, db_estado
  );
endinterface

// File: rtl/tx_serial_fifo.sv
// Word queue in front of the shifter. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module tx_serial_fifo #(
  parameter int LARGURA = 7,
  parameter int PROF    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [LARGURA-1:0] din,
  output logic [LARGURA-1:0] dout,
  output logic               vazio,
  output logic               cheio
);
  localparam int AW = $clog2(PROF);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [LARGURA-1:0] mem [PROF];
  logic               do_push;
  logic               do_pop;

  assign vazio   = (wr_ptr == rd_ptr);
  assign cheio   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !cheio;
  assign do_pop  = pop && !vazio;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; a write while full is ignored even if a pop happens too.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tx_serial_param.sv
// Parametrised asynchronous serial transmitter: edge-detected enqueue into a
// small FIFO, then frames of start, data LSB first, optional parity and one or
// two stop bits, each bit lasting DIV_BAUD clocks.
module tx_serial_param
  import tx_serial_pkg::*;
#(
  parameter int N_DADOS   = 7,
  parameter int DIV_BAUD  = 5208,
  parameter int PROF_FIFO = 4
) (
  input  logic               clock,
  input  logic               reset,
  tx_serial_param_if.slave   bus
);
  localparam int BW = (DIV_BAUD > 1) ? $clog2(DIV_BAUD) : 1;
  localparam int SW = N_DADOS + 4;

  estado_t            estado;
  logic               partida_q;
  logic               push_r;
  logic [N_DADOS-1:0] dados_r;
  logic               descartado_r;
  logic               saida_r;
  logic               pronto_r;
  logic [BW-1:0]      baud;
  logic [3:0]         bits_rest;
  logic [SW-1:0]      shift;
  logic [N_DADOS-1:0] fifo_dout;
  logic               vazio;
  logic               cheio;
  logic               pop;
  logic [SW-1:0]      quadro;
  logic [3:0]         n_bits;
  logic               par_bit;

  assign pop = (estado == CARREGA);

  tx_serial_fifo #(
    .LARGURA (N_DADOS),
    .PROF    (PROF_FIFO)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_r),
    .pop   (pop),
    .din   (dados_r),
    .dout  (fifo_dout),
    .vazio (vazio),
    .cheio (cheio)
  );

  // Rising-edge detect on partida; capture the word and flag drops when full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      partida_q    <= 1'b0;
      push_r       <= 1'b0;
      dados_r      <= '0;
      descartado_r <= 1'b0;
    end else begin
      partida_q    <= bus.partida;
      push_r       <= bus.partida && !partida_q;
      descartado_r <= push_r && cheio;
      if (bus.partida && !partida_q) dados_r <= bus.dados;
    end
  end

  // Frame image for the word at the FIFO head, built with the current mode
  // bits; unused upper positions are ones so the stop bits come for free.
  always_comb begin
    par_bit                = (^fifo_dout) ^ (bus.modo_paridade == IMPAR);
    quadro                 = '1;
    quadro[0]              = 1'b0;
    quadro[N_DADOS:1]      = fifo_dout;
    n_bits                 = 4'(1 + N_DADOS);
    if (paridade_ativa(bus.modo_paridade)) begin
      quadro[N_DADOS+1] = par_bit;
      n_bits            = n_bits + 4'd1;
    end
    n_bits = n_bits + (bus.dois_stop ? 4'd2 : 4'd1);
  end

  // Transmit FSM with registered line and pronto; mode bits are frozen into
  // the shift register and bit count at CARREGA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      saida_r   <= 1'b1;
      pronto_r  <= 1'b0;
      baud      <= '0;
      bits_rest <= '0;
      shift     <= '1;
    end else begin
      pronto_r <= 1'b0;
      case (estado)
        OCIOSO: begin
          saida_r <= 1'b1;
          if (!vazio) estado <= CARREGA;
        end
        CARREGA: begin
          saida_r   <= quadro[0];
          shift     <= {1'b1, quadro[SW-1:1]};
          bits_rest <= n_bits;
          baud      <= '0;
          estado    <= TRANSMITE;
        end
        TRANSMITE: begin
          if (baud == BW'(DIV_BAUD - 1)) begin
            baud <= '0;
            if (bits_rest == 4'd1) begin
              estado   <= FINAL;
              saida_r  <= 1'b1;
              pronto_r <= 1'b1;
            end else begin
              bits_rest <= bits_rest - 4'd1;
              saida_r   <= shift[0];
              shift     <= {1'b1, shift[SW-1:1]};
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        FINAL: begin
          saida_r <= 1'b1;
          estado  <= vazio ? OCIOSO : CARREGA;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.saida_serial = saida_r;
  assign bus.pronto       = pronto_r;
  assign bus.descartado   = descartado_r;
  assign bus.cheio        = cheio;
  assign bus.ocupado      = (estado != OCIOSO) || !vazio;
  assign bus.db_estado    = estado;

endmodule

// File: tb/tb_tx_serial_param.sv
// Bench for tx_serial_param: a 7-bit and an 8-bit instance with a short baud
// divisor; every frame is compared cycle by cycle against a bit list built
// from the framing rules.
module tb_tx_serial_param;
  localparam int DIV = 4;

  logic       clock;
  logic       reset;
  logic       partida7;
  logic       partida8;
  logic [7:0] dados;
  logic [1:0] modo;
  logic       dois;
  logic       sel8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_final = 0;
  int np7 = 0, np8 = 0, nd7 = 0, nd8 = 0;

  logic [7:0] exp_q[$];

  tx_serial_param_if #(.N_DADOS(7)) if7();
  tx_serial_param_if #(.N_DADOS(8)) if8();

  assign if7.partida       = partida7;
  assign if7.dados         = dados[6:0];
  assign if7.modo_paridade = modo;
  assign if7.dois_stop     = dois;
  assign if8.partida       = partida8;
  assign if8.dados         = dados;
  assign if8.modo_paridade = modo;
  assign if8.dois_stop     = dois;

  tx_serial_param #(.N_DADOS(7), .DIV_BAUD(DIV), .PROF_FIFO(4)) dut7 (
    .clock (clock),
    .reset (reset),
    .bus   (if7)
  );

  tx_serial_param #(.N_DADOS(8), .DIV_BAUD(DIV), .PROF_FIFO(4)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (if8)
  );

  logic       line_s, pronto_s, ocupado_s, cheio_s;
  logic [3:0] estado_s;
  assign line_s    = sel8 ? if8.saida_serial : if7.saida_serial;
  assign pronto_s  = sel8 ? if8.pronto       : if7.pronto;
  assign ocupado_s = sel8 ? if8.ocupado      : if7.ocupado;
  assign cheio_s   = sel8 ? if8.cheio        : if7.cheio;
  assign estado_s  = sel8 ? if8.db_estado    : if7.db_estado;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cycle counter and pulse counters
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (if7.pronto)     np7 <= np7 + 1;
    if (if8.pronto)     np8 <= np8 + 1;
    if (if7.descartado) nd7 <= nd7 + 1;
    if (if8.descartado) nd8 <= nd8 + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference framing: start, n data bits LSB first, parity by counting
  // ones (even/odd modes only), then one or two stop bits.
  function automatic void build_frame(input int n, input logic [7:0] d,
                                      input logic [1:0] m, input logic ds,
                                      output logic bq[$]);
    int ones;
    bq = {};
    bq.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      bq.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (m == 2'b01) bq.push_back(logic'(ones % 2));
    if (m == 2'b10) bq.push_back(logic'(1 - (ones % 2)));
    bq.push_back(1'b1);
    if (ds) bq.push_back(1'b1);
  endfunction

  // driver: one enqueue request held for 'hold' cycles
  task automatic pulse(input bit use8, input logic [7:0] d, input int hold, input bit keep);
    if (keep) exp_q.push_back(d);
    dados = d;
    if (use8) partida8 = 1'b1;
    else      partida7 = 1'b1;
    repeat (hold) step();
    partida7 = 1'b0;
    partida8 = 1'b0;
    step();
  endtask

  // scoreboard: pop the next expected word and follow its frame on the line
  task automatic check_frame(input int n, input logic [1:0] m, input logic ds,
                             input logic [1:0] m_after, input bit started, input bit b2b);
    logic [7:0] w;
    logic       bq[$];
    logic       obs;
    int         waited;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    w = exp_q.pop_front();
    build_frame(n, w, m, ds, bq);
    if (!started) begin
      waited = 0;
      while (line_s !== 1'b0 && waited < 300) begin
        step();
        waited++;
      end
      if (waited >= 300) begin
        chk("start_timeout", {31'd0, line_s}, 32'd0);
        return;
      end
    end
    if (b2b) chk("frame_gap", cyc - last_final, 32'd2);
    modo = m_after;
    foreach (bq[b]) begin
      obs = bq[b];
      for (int c = 0; c < DIV; c++) begin
        if (!(b == 0 && c == 0)) step();
        if (line_s !== bq[b]) obs = line_s;
      end
      chk($sformatf("w%0h_bit%0d", w, b), {31'd0, obs}, {31'd0, bq[b]});
    end
    step();
    chk("pronto_pulse", {31'd0, pronto_s}, 32'd1);
    chk("final_idle", {31'd0, line_s}, 32'd1);
    last_final = cyc;
  endtask

  initial begin
    int p0, d0, t0;
    logic [7:0] rd;
    logic [1:0] rm;
    logic       rs;

    reset = 1'b0;
    partida7 = 1'b0;
    partida8 = 1'b0;
    dados = '0;
    modo = 2'b01;
    dois = 1'b0;
    sel8 = 1'b0;
    step();
    step();
    chk("rst_line7",  {31'd0, if7.saida_serial}, 32'd1);
    chk("rst_pronto7", {31'd0, if7.pronto}, 32'd0);
    chk("rst_ocup7",  {31'd0, if7.ocupado}, 32'd0);
    chk("rst_cheio7", {31'd0, if7.cheio}, 32'd0);
    chk("rst_desc7",  {31'd0, if7.descartado}, 32'd0);
    chk("rst_est7",   {28'd0, if7.db_estado}, 32'd0);
    chk("rst_line8",  {31'd0, if8.saida_serial}, 32'd1);
    chk("rst_ocup8",  {31'd0, if8.ocupado}, 32'd0);
    reset = 1'b1;
    step();
    step();

    // 7E1, 35h, with latency check
    p0 = np7;
    modo = 2'b01;
    dois = 1'b0;
    exp_q.push_back(8'h35);
    dados = 8'h35;
    partida7 = 1'b1;
    step();
    partida7 = 1'b0;
    chk("lat_t0_est", {28'd0, estado_s}, 32'd0);
    step();
    chk("lat_t1_est", {28'd0, estado_s}, 32'd0);
    chk("lat_t1_line", {31'd0, line_s}, 32'd1);
    step();
    chk("lat_t2_est", {28'd0, estado_s}, 32'd1);
    chk("lat_t2_line", {31'd0, line_s}, 32'd1);
    step();
    chk("lat_t3_est", {28'd0, estado_s}, 32'd2);
    check_frame(7, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0);
    step();
    chk("t1_pronto_cnt", np7 - p0, 32'd1);
    chk("t1_ocup_idle", {31'd0, ocupado_s}, 32'd0);

    // 7Fh odd (mode changed mid-frame to even, must not matter), then even
    modo = 2'b10;
    pulse(1'b0, 8'h7F, 1, 1'b1);
    check_frame(7, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0);
    pulse(1'b0, 8'h7F, 1, 1'b1);
    check_frame(7, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0);
    step();

    // 8N2, A5h on the 8-bit instance
    sel8 = 1'b1;
    modo = 2'b00;
    dois = 1'b1;
    pulse(1'b1, 8'hA5, 1, 1'b1);
    check_frame(8, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      modo = rm;
      dois = rs;
      pulse(1'b1, rd, 1, 1'b1);
      check_frame(8, rm, rs, rm, 1'b0, 1'b0);
    end
    step();
    chk("n8_pronto_cnt", np8, 32'd4);
    sel8 = 1'b0;

    // partida held 25 cycles: one frame, nothing dropped
    modo = 2'b01;
    dois = 1'b0;
    p0 = np7;
    d0 = nd7;
    exp_q.push_back(8'h55);
    fork
      pulse(1'b0, 8'h55, 25, 1'b0);
      check_frame(7, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0);
    join
    repeat (20) step();
    chk("hold_pronto_cnt", np7 - p0, 32'd1);
    chk("hold_desc_cnt", nd7 - d0, 32'd0);
    chk("hold_ocup", {31'd0, ocupado_s}, 32'd0);

    // randomized frames on the 7-bit instance
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 127));
      rm = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      modo = rm;
      dois = rs;
      pulse(1'b0, rd, 1, 1'b1);
      check_frame(7, rm, rs, rm, 1'b0, 1'b0);
    end
    step();

    // overflow: 01h..06h while idle, 06h dropped
    modo = 2'b01;
    dois = 1'b0;
    p0 = np7;
    d0 = nd7;
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          if (i == 6) chk("ovf_cheio", {31'd0, cheio_s}, 32'd1);
          pulse(1'b0, 8'(i), 1, 1'b0);
        end
        step();
        step();
        chk("ovf_desc_cnt", nd7 - d0, 32'd1);
        chk("ovf_cheio_after", {31'd0, cheio_s}, 32'd1);
      end
      begin
        check_frame(7, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) check_frame(7, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1);
        step();
        chk("ovf_ocup_fall", {31'd0, ocupado_s}, 32'd0);
      end
    join
    chk("ovf_pronto_cnt", np7 - p0, 32'd5);

    // reset during data bit 3 of 35h with two words queued
    p0 = np7;
    dados = 8'h35;
    partida7 = 1'b1;
    step();
    t0 = cyc;
    partida7 = 1'b0;
    step();
    pulse(1'b0, 8'h11, 1, 1'b0);
    pulse(1'b0, 8'h22, 1, 1'b0);
    while (cyc < t0 + 3 + 4 * DIV + 2) step();
    chk("rst_mid_line", {31'd0, line_s}, 32'd0);
    chk("rst_mid_est", {28'd0, estado_s}, 32'd2);
    chk("rst_mid_ocup", {31'd0, ocupado_s}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_line", {31'd0, line_s}, 32'd1);
    chk("rst_async_ocup", {31'd0, ocupado_s}, 32'd0);
    chk("rst_async_est", {28'd0, estado_s}, 32'd0);
    chk("rst_async_pronto", {31'd0, pronto_s}, 32'd0);
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    chk("rst_no_pronto", np7 - p0, 32'd0);
    chk("rst_fifo_empty", {31'd0, ocupado_s}, 32'd0);
    pulse(1'b0, 8'h7E, 1, 1'b1);
    check_frame(7, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0);
    repeat (5) step();
    chk("post_rst_pronto", np7 - p0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
